control: RTL and testbench
==========================

Name: control

Overview:
- Main decoder for the 16-bit single-cycle basic CPU.
- Maps the 4-bit instruction opcode to datapath control strobes: register-file write, ALU operand/op select, memory read/write, writeback mux, branch, immediate-extension mode and PC-to-register select.
- Decode is combinational (zero latency).
- A single registered halt flag makes HLT sticky.

Parameters:
- None. Opcode encodings and the ALU-op and ext-mode codes are fixed constants in the shared package.

Ports:
- clk  in  1  system clock; only the halt flag is clocked.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  4  instruction[15:12].
- regwrite  out  1  write the register file.
- alusrc  out  1  ALU operand B: 1 = extended immediate, 0 = register.
- memread  out  1  data-memory read.
- memwrite  out  1  data-memory write.
- aluop  out  4  ALU operation code.
- memtoreg  out  1  writeback from memory (1) or ALU (0).
- branch  out  1  instruction is a branch.
- alusext  out  3  immediate extraction/extension mode.
- pcread  out  1  writeback source is PC+2.
- halt  out  1  processor halted.

Behaviour:
- Opcode map:
  - 0000 ADD, 0001 SUB, 0010 XOR, 0011 RED, 0100 SLL, 0101 SRA, 0110 ROR, 0111 PADDSB
  - 1000 LW, 1001 SW, 1010 LLB, 1011 LHB
  - 1100 B, 1101 BR, 1110 PCS, 1111 HLT
- aluop:
  - opcodes 0000–0111 and LLB/LHB: aluop = opcode.
  - LW, SW, B, BR, PCS, HLT: aluop = 0000 (address add or don't-care).
- alusext codes:
  - 000 none
  - 001 imm4 zero-extended (shift amount)
  - 010 imm4 sign-extended, shifted left by 1 (LW/SW offset)
  - 011 imm8 zero-extended (LLB)
  - 100 imm8 placed in upper byte (LHB)
  - 101 imm9 sign-extended, shifted left by 1 (B)
  - 110, 111 unused
- Per-opcode outputs, listed as regwrite alusrc memread memwrite memtoreg branch pcread alusext:
  - ADD, SUB, XOR, RED, PADDSB: 1 0 0 0 0 0 0 000
  - SLL, SRA, ROR: 1 1 0 0 0 0 0 001
  - LW: 1 1 1 0 1 0 0 010
  - SW: 0 1 0 1 0 0 0 010
  - LLB: 1 1 0 0 0 0 0 011
  - LHB: 1 1 0 0 0 0 0 100
  - B: 0 0 0 0 0 1 0 101
  - BR: 0 0 0 0 0 1 0 000 (target taken from register)
  - PCS: 1 0 0 0 0 0 1 000
  - HLT: all 0, alusext 000
- Decode is purely combinational from opcode. Outputs settle within the same cycle; no clock edge is needed.
- Halt flag:
  - halted_q resets asynchronously to 0 when rst_n = 0.
  - On rising clk with rst_n = 1 and opcode = 1111, halted_q <= 1.
  - The flag is sticky until the next reset.
- halt = halted_q OR (opcode == 1111).
- While halted_q = 1, regwrite, memread, memwrite, branch and pcread are forced to 0. aluop, alusrc, alusext and memtoreg still decode normally.
- Reset asserted mid-operation clears halted_q immediately; decode resumes in the same cycle.
- There are no undefined opcodes; all 16 codes are decoded. No X outputs for any known input.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams (OP_ADD … OP_HLT)
  - ALU-op codes
  - EXT_* codes for alusext
- Sub-modules: none. One combinational decode block plus one flop is natural.
- Optionally split the decode into control_decode if the halt gating is kept separate.

Test Plan:
- rst_n low then high, opcode 1000 → regwrite 1, alusrc 1, memread 1, memtoreg 1, memwrite 0, aluop 0000, alusext 010, halt 0.
- opcode 0000 → regwrite 1, alusrc 0, memread 0, aluop 0000, alusext 000. Then opcode 0100 → regwrite 1, alusrc 1, memread 0, aluop 0100, alusext 001.
- Sweep all 16 opcodes without any clock edge → every output matches the table. SW gives memwrite 1, regwrite 0. B gives branch 1, alusext 101. PCS gives pcread 1, regwrite 1.
- opcode 1111 → halt 1 combinationally. After one rising clk, switch opcode to 0000 → halt stays 1 and regwrite 0, while aluop still reads 0000.
- While halted, pulse rst_n low asynchronously (no clk) → halt 0 immediately. Opcode 0000 then gives regwrite 1.
- opcode 1111 held while rst_n = 0 across clk edges → halted_q stays 0. Releasing reset and then one clk → halted_q becomes 1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit single-cycle CPU: opcodes, ALU ops,
// immediate-extension modes and the decoded control bundle.
package cpu_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned ALU_W = 4;
  localparam int unsigned EXT_W = 3;

  localparam logic [OP_W-1:0] OP_ADD    = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB    = 4'h1;
  localparam logic [OP_W-1:0] OP_XOR    = 4'h2;
  localparam logic [OP_W-1:0] OP_RED    = 4'h3;
  localparam logic [OP_W-1:0] OP_SLL    = 4'h4;
  localparam logic [OP_W-1:0] OP_SRA    = 4'h5;
  localparam logic [OP_W-1:0] OP_ROR    = 4'h6;
  localparam logic [OP_W-1:0] OP_PADDSB = 4'h7;
  localparam logic [OP_W-1:0] OP_LW     = 4'h8;
  localparam logic [OP_W-1:0] OP_SW     = 4'h9;
  localparam logic [OP_W-1:0] OP_LLB    = 4'hA;
  localparam logic [OP_W-1:0] OP_LHB    = 4'hB;
  localparam logic [OP_W-1:0] OP_B      = 4'hC;
  localparam logic [OP_W-1:0] OP_BR     = 4'hD;
  localparam logic [OP_W-1:0] OP_PCS    = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT    = 4'hF;

  localparam logic [ALU_W-1:0] ALU_ADD    = 4'h0;
  localparam logic [ALU_W-1:0] ALU_SUB    = 4'h1;
  localparam logic [ALU_W-1:0] ALU_XOR    = 4'h2;
  localparam logic [ALU_W-1:0] ALU_RED    = 4'h3;
  localparam logic [ALU_W-1:0] ALU_SLL    = 4'h4;
  localparam logic [ALU_W-1:0] ALU_SRA    = 4'h5;
  localparam logic [ALU_W-1:0] ALU_ROR    = 4'h6;
  localparam logic [ALU_W-1:0] ALU_PADDSB = 4'h7;
  localparam logic [ALU_W-1:0] ALU_LLB    = 4'hA;
  localparam logic [ALU_W-1:0] ALU_LHB    = 4'hB;

  localparam logic [EXT_W-1:0] EXT_NONE    = 3'd0;
  localparam logic [EXT_W-1:0] EXT_IMM4_ZX = 3'd1;
  localparam logic [EXT_W-1:0] EXT_IMM4_SX = 3'd2;
  localparam logic [EXT_W-1:0] EXT_IMM8_ZX = 3'd3;
  localparam logic [EXT_W-1:0] EXT_IMM8_HI = 3'd4;
  localparam logic [EXT_W-1:0] EXT_IMM9_SX = 3'd5;

  typedef struct packed {
    logic             regwrite;
    logic             alusrc;
    logic             memread;
    logic             memwrite;
    logic             memtoreg;
    logic             branch;
    logic             pcread;
    logic [EXT_W-1:0] alusext;
    logic [ALU_W-1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Purely combinational opcode-to-control-strobe decoder (no halt gating).
module control_decode
  import cpu_pkg::*;
(
  input  logic [OP_W-1:0] opcode_i,
  output ctrl_t           ctrl_o
);

  always_comb begin
    ctrl_o         = '0;
    ctrl_o.alusext = EXT_NONE;
    ctrl_o.aluop   = ALU_ADD;
    case (opcode_i)
      OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.aluop    = ALU_W'(opcode_i);
      end
      OP_SLL, OP_SRA, OP_ROR: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.alusext  = EXT_IMM4_ZX;
        ctrl_o.aluop    = ALU_W'(opcode_i);
      end
      OP_LW: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.memread  = 1'b1;
        ctrl_o.memtoreg = 1'b1;
        ctrl_o.alusext  = EXT_IMM4_SX;
      end
      OP_SW: begin
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.memwrite = 1'b1;
        ctrl_o.alusext  = EXT_IMM4_SX;
      end
      OP_LLB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.alusext  = EXT_IMM8_ZX;
        ctrl_o.aluop    = ALU_LLB;
      end
      OP_LHB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.alusext  = EXT_IMM8_HI;
        ctrl_o.aluop    = ALU_LHB;
      end
      OP_B: begin
        ctrl_o.branch  = 1'b1;
        ctrl_o.alusext = EXT_IMM9_SX;
      end
      // Branch target comes from a register, so no immediate is extracted.
      OP_BR: ctrl_o.branch = 1'b1;
      OP_PCS: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.pcread   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control.sv
// Main CPU decoder: combinational control strobes plus a sticky halt flag
// that suppresses all state-changing strobes once HLT has been clocked.
module control
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  opcode,
  output logic             regwrite,
  output logic             alusrc,
  output logic             memread,
  output logic             memwrite,
  output logic [ALU_W-1:0] aluop,
  output logic             memtoreg,
  output logic             branch,
  output logic [EXT_W-1:0] alusext,
  output logic             pcread,
  output logic             halt
);

  ctrl_t ctrl;
  logic  halted_q;
  logic  halted_d;

  control_decode u_decode (
    .opcode_i (opcode),
    .ctrl_o   (ctrl)
  );

  always_comb begin
    halted_d = halted_q | (opcode == OP_HLT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halted_q <= 1'b0;
    else        halted_q <= halted_d;
  end

  // Strobes that change architectural state are masked while halted.
  assign regwrite = ctrl.regwrite & ~halted_q;
  assign memread  = ctrl.memread  & ~halted_q;
  assign memwrite = ctrl.memwrite & ~halted_q;
  assign branch   = ctrl.branch   & ~halted_q;
  assign pcread   = ctrl.pcread   & ~halted_q;
  assign alusrc   = ctrl.alusrc;
  assign memtoreg = ctrl.memtoreg;
  assign alusext  = ctrl.alusext;
  assign aluop    = ctrl.aluop;
  assign halt     = halted_q | (opcode == OP_HLT);

endmodule

// File: tb/tb_control.sv
// Scoreboard bench for the CPU main decoder and its sticky halt flag.
module tb_control;

  logic       clk;
  logic       rst_n;
  logic [3:0] opcode;
  logic       regwrite, alusrc, memread, memwrite, memtoreg, branch, pcread, halt;
  logic [3:0] aluop;
  logic [2:0] alusext;

  int checks;
  int failures;

  typedef struct {
    string      name;
    logic [14:0] vec;
  } exp_t;

  exp_t sb[$];

  control dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .regwrite (regwrite),
    .alusrc   (alusrc),
    .memread  (memread),
    .memwrite (memwrite),
    .aluop    (aluop),
    .memtoreg (memtoreg),
    .branch   (branch),
    .alusext  (alusext),
    .pcread   (pcread),
    .halt     (halt)
  );

  // {regwrite,alusrc,memread,memwrite,memtoreg,branch,pcread, alusext, aluop, halt}
  function automatic logic [14:0] model(input logic [3:0] op, input logic halted);
    logic [6:0] s;
    logic [2:0] e;
    logic [3:0] a;
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd7: begin s = 7'b1000000; e = 3'd0; end
      4'd4, 4'd5, 4'd6:             begin s = 7'b1100000; e = 3'd1; end
      4'd8:                         begin s = 7'b1110100; e = 3'd2; end
      4'd9:                         begin s = 7'b0101000; e = 3'd2; end
      4'd10:                        begin s = 7'b1100000; e = 3'd3; end
      4'd11:                        begin s = 7'b1100000; e = 3'd4; end
      4'd12:                        begin s = 7'b0000010; e = 3'd5; end
      4'd13:                        begin s = 7'b0000010; e = 3'd0; end
      4'd14:                        begin s = 7'b1000001; e = 3'd0; end
      default:                      begin s = 7'b0000000; e = 3'd0; end
    endcase
    if (halted) s = s & 7'b0100100;
    a = ((op <= 4'd7) || (op == 4'd10) || (op == 4'd11)) ? op : 4'd0;
    return {s, e, a, halted | (op == 4'hF)};
  endfunction

  function automatic logic [14:0] observed();
    return {regwrite, alusrc, memread, memwrite, memtoreg, branch, pcread,
            alusext, aluop, halt};
  endfunction

  task automatic tick();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
  endtask

  task automatic push(input string name, input logic [3:0] op, input logic halted);
    exp_t e;
    opcode = op;
    e.name = name;
    e.vec  = model(op, halted);
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    logic [14:0] got;
    rst_n = 1'b0;
    push("reset_lw", 4'h8, 1'b0);
    #2 rst_n = 1'b1;
    #1;
    e = sb.pop_front();
    got = observed();
    checks++;
    if (got !== e.vec) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", e.name, got, e.vec);
    end
  endtask

  task automatic test_alu();
    exp_t e;
    logic [14:0] got;
    push("alu_add", 4'h0, 1'b0);
    push("alu_sll", 4'h4, 1'b0);
    opcode = 4'h0;
    #1;
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      got = observed();
      checks++;
      if (got !== e.vec) begin
        failures++;
        $display("FAIL %s got=%h exp=%h", e.name, got, e.vec);
      end
      opcode = 4'h4;
      #1;
    end
  endtask

  task automatic test_sweep(input logic halted, input string tag);
    exp_t e;
    logic [14:0] got;
    for (int i = 0; i < 16; i++) begin
      push($sformatf("%s_op%0d", tag, i), 4'(i), halted);
      #1;
      e = sb.pop_front();
      got = observed();
      checks++;
      if (got !== e.vec) begin
        failures++;
        $display("FAIL %s got=%h exp=%h", e.name, got, e.vec);
      end
    end
  endtask

  task automatic test_halt();
    exp_t e;
    logic [14:0] got;
    push("halt_comb", 4'hF, 1'b0);
    #1;
    e = sb.pop_front();
    got = observed();
    checks++;
    if (got !== e.vec) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", e.name, got, e.vec);
    end
    tick();
    push("halt_sticky_add", 4'h0, 1'b1);
    #1;
    e = sb.pop_front();
    got = observed();
    checks++;
    if (got !== e.vec) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", e.name, got, e.vec);
    end
    tick();
    test_sweep(1'b1, "halted");
  endtask

  task automatic test_async_reset();
    exp_t e;
    logic [14:0] got;
    opcode = 4'h0;
    #1 rst_n = 1'b0;
    push("async_clr", 4'h0, 1'b0);
    #1;
    e = sb.pop_front();
    got = observed();
    checks++;
    if (got !== e.vec) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", e.name, got, e.vec);
    end
    rst_n = 1'b1;
    push("after_release", 4'h0, 1'b0);
    #1;
    e = sb.pop_front();
    got = observed();
    checks++;
    if (got !== e.vec) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", e.name, got, e.vec);
    end
  endtask

  task automatic test_reset_hold();
    exp_t e;
    logic [14:0] got;
    rst_n  = 1'b0;
    opcode = 4'hF;
    repeat (3) tick();
    push("hold_no_halt", 4'h0, 1'b0);
    #1;
    e = sb.pop_front();
    got = observed();
    checks++;
    if (got !== e.vec) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", e.name, got, e.vec);
    end
    opcode = 4'hF;
    #1 rst_n = 1'b1;
    tick();
    push("halt_after_release", 4'h2, 1'b1);
    #1;
    e = sb.pop_front();
    got = observed();
    checks++;
    if (got !== e.vec) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", e.name, got, e.vec);
    end
  endtask

  initial begin
    clk      = 1'b0;
    rst_n    = 1'b0;
    opcode   = 4'h0;
    checks   = 0;
    failures = 0;
    #3;
    test_reset();
    test_alu();
    test_sweep(1'b0, "sweep");
    test_halt();
    test_async_reset();
    test_reset_hold();
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
